vtc_cfg_sequencer: RTL

AXI4-Lite master that programs the video timing controller (VTC) control port after reset or on request. It walks a fixed 10-entry register table derived from timing parameters, issues one write per entry, and checks each write response. It optionally reads the table back and verifies it. It then reports done or error. It sits beside the video system wrapper and drives its vtc_ctrl_* slave port, on the same clock as that port.

---
 rtl/vtc_cfg_sequencer.sv | 299 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/vtc_cfg_sequencer.sv
// vtc_cfg_sequencer: AXI4-Lite master that writes the fixed VTC timing table and reports done/error.
// Optional readback/verify of every entry is compiled in with `define VTC_READBACK_EN.
module vtc_cfg_sequencer #(
    parameter int unsigned H_ACTIVE    = 1280,
    parameter int unsigned H_FP        = 110,
    parameter int unsigned H_SYNC      = 40,
    parameter int unsigned H_BP        = 220,
    parameter int unsigned V_ACTIVE    = 720,
    parameter int unsigned V_FP        = 5,
    parameter int unsigned V_SYNC      = 5,
    parameter int unsigned V_BP        = 20,
    parameter logic [31:0] CTRL_VAL    = 32'h03F7_EF07,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        error,
    output logic [1:0]  err_code,
    output logic [3:0]  err_index,
    output logic [8:0]  vtc_ctrl_awaddr,
    output logic        vtc_ctrl_awvalid,
    input  logic        vtc_ctrl_awready,
    output logic [31:0] vtc_ctrl_wdata,
    output logic [3:0]  vtc_ctrl_wstrb,
    output logic        vtc_ctrl_wvalid,
    input  logic        vtc_ctrl_wready,
    input  logic [1:0]  vtc_ctrl_bresp,
    input  logic        vtc_ctrl_bvalid,
    output logic        vtc_ctrl_bready,
    output logic [8:0]  vtc_ctrl_araddr,
    output logic        vtc_ctrl_arvalid,
    input  logic        vtc_ctrl_arready,
    input  logic [31:0] vtc_ctrl_rdata,
    input  logic [1:0]  vtc_ctrl_rresp,
    input  logic        vtc_ctrl_rvalid,
    output logic        vtc_ctrl_rready
);

    localparam logic [12:0] HA   = 13'(H_ACTIVE);
    localparam logic [12:0] VA   = 13'(V_ACTIVE);
    localparam logic [12:0] HS_S = 13'(H_ACTIVE + H_FP);
    localparam logic [12:0] HS_E = 13'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [12:0] HT   = 13'(H_ACTIVE + H_FP + H_SYNC + H_BP);
    localparam logic [12:0] VS_S = 13'(V_ACTIVE + V_FP);
    localparam logic [12:0] VS_E = 13'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [12:0] VT   = 13'(V_ACTIVE + V_FP + V_SYNC + V_BP);

    localparam int unsigned TW       = $clog2(TIMEOUT_CYC) + 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [3:0]  LAST_IDX = 4'd9;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_WR    = 3'd1;
    localparam logic [2:0] S_WRESP = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;
`ifdef VTC_READBACK_EN
    localparam logic [2:0] S_RB_AR = 3'd5;
    localparam logic [2:0] S_RB_R  = 3'd6;
`endif

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_RESP = 2'd1;
    localparam logic [1:0] ERR_CMP  = 2'd2;
    localparam logic [1:0] ERR_TMO  = 2'd3;

    function automatic logic [31:0] pack2(input logic [12:0] hi, input logic [12:0] lo);
        return {3'b000, hi, 3'b000, lo};
    endfunction

    function automatic logic [8:0] tbl_addr(input logic [3:0] i);
        case (i)
            4'd0:    return 9'h060;
            4'd1:    return 9'h068;
            4'd2:    return 9'h06C;
            4'd3:    return 9'h070;
            4'd4:    return 9'h074;
            4'd5:    return 9'h078;
            4'd6:    return 9'h080;
            4'd7:    return 9'h084;
            4'd8:    return 9'h088;
            default: return 9'h000;
        endcase
    endfunction

    function automatic logic [31:0] tbl_data(input logic [3:0] i);
        case (i)
            4'd0:    return pack2(VA, HA);
            4'd1:    return 32'h0000_0002;
            4'd2:    return 32'h0000_003F;
            4'd3:    return {19'd0, HT};
            4'd4:    return {19'd0, VT};
            4'd5:    return pack2(HS_E, HS_S);
            4'd6:    return pack2(HA, HA);
            4'd7:    return pack2(VS_E, VS_S);
            4'd8:    return pack2(HS_S, HS_S);
            4'd9:    return CTRL_VAL;
            default: return '0;
        endcase
    endfunction

    logic [2:0]    state_q, state_d;
    logic [3:0]    idx_q, idx_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          awvalid_q, awvalid_d;
    logic          wvalid_q, wvalid_d;
    logic [8:0]    awaddr_q, awaddr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [1:0]    err_code_q, err_code_d;
    logic [3:0]    err_index_q, err_index_d;
    logic          tmo_hit, go_err, load_wr;
    logic [1:0]    err_sel;
`ifdef VTC_READBACK_EN
    logic          arvalid_q, arvalid_d;
    logic [8:0]    araddr_q, araddr_d;
`endif

    assign busy = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERR);

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        awaddr_d    = awaddr_q;
        wdata_d     = wdata_q;
        err_code_d  = err_code_q;
        err_index_d = err_index_q;
        go_err      = 1'b0;
        err_sel     = ERR_NONE;
        load_wr     = 1'b0;
        tmo_hit     = (tmo_q == TMO_LAST);
`ifdef VTC_READBACK_EN
        arvalid_d   = arvalid_q;
        araddr_d    = araddr_q;
`endif
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start) begin
                    idx_d       = '0;
                    err_code_d  = ERR_NONE;
                    err_index_d = '0;
                    load_wr     = 1'b1;
                end
            end
            S_WR: begin
                // Exit is taken from the registered valids, so one settle cycle follows the last handshake.
                if (!awvalid_q && !wvalid_q) begin
                    state_d = S_WRESP;
                end else begin
                    if (awvalid_q && vtc_ctrl_awready) awvalid_d = 1'b0;
                    if (wvalid_q && vtc_ctrl_wready) wvalid_d = 1'b0;
                    if (tmo_hit) begin
                        go_err  = 1'b1;
                        err_sel = ERR_TMO;
                    end
                end
            end
            S_WRESP: begin
                if (vtc_ctrl_bvalid) begin
                    if (vtc_ctrl_bresp != 2'b00) begin
                        go_err  = 1'b1;
                        err_sel = ERR_RESP;
                    end else if (idx_q == LAST_IDX) begin
`ifdef VTC_READBACK_EN
                        idx_d     = '0;
                        state_d   = S_RB_AR;
                        arvalid_d = 1'b1;
                        araddr_d  = tbl_addr(4'd0);
`else
                        state_d   = S_DONE;
`endif
                    end else begin
                        idx_d   = idx_q + 4'd1;
                        load_wr = 1'b1;
                    end
                end else if (tmo_hit) begin
                    go_err  = 1'b1;
                    err_sel = ERR_TMO;
                end
            end
`ifdef VTC_READBACK_EN
            S_RB_AR: begin
                if (vtc_ctrl_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = S_RB_R;
                end else if (tmo_hit) begin
                    go_err  = 1'b1;
                    err_sel = ERR_TMO;
                end
            end
            S_RB_R: begin
                if (vtc_ctrl_rvalid) begin
                    if (vtc_ctrl_rresp != 2'b00) begin
                        go_err  = 1'b1;
                        err_sel = ERR_RESP;
                    end else if (vtc_ctrl_rdata != tbl_data(idx_q)) begin
                        go_err  = 1'b1;
                        err_sel = ERR_CMP;
                    end else if (idx_q == LAST_IDX) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d     = idx_q + 4'd1;
                        state_d   = S_RB_AR;
                        arvalid_d = 1'b1;
                        araddr_d  = tbl_addr(idx_d);
                    end
                end else if (tmo_hit) begin
                    go_err  = 1'b1;
                    err_sel = ERR_TMO;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        if (load_wr) begin
            state_d   = S_WR;
            awvalid_d = 1'b1;
            wvalid_d  = 1'b1;
            awaddr_d  = tbl_addr(idx_d);
            wdata_d   = tbl_data(idx_d);
        end
        if (go_err) begin
            state_d     = S_ERR;
            err_code_d  = err_sel;
            err_index_d = idx_q;
            awvalid_d   = 1'b0;
            wvalid_d    = 1'b0;
`ifdef VTC_READBACK_EN
            arvalid_d   = 1'b0;
`endif
        end

        if (state_d != state_q || !busy) tmo_d = '0;
        else                             tmo_d = tmo_q + TW'(1);
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            tmo_q       <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            awaddr_q    <= '0;
            wdata_q     <= '0;
            err_code_q  <= '0;
            err_index_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            tmo_q       <= tmo_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            awaddr_q    <= awaddr_d;
            wdata_q     <= wdata_d;
            err_code_q  <= err_code_d;
            err_index_q <= err_index_d;
        end
    end

    assign done             = (state_q == S_DONE);
    assign error            = (state_q == S_ERR);
    assign err_code         = err_code_q;
    assign err_index        = err_index_q;
    assign vtc_ctrl_awaddr  = awaddr_q;
    assign vtc_ctrl_awvalid = awvalid_q;
    assign vtc_ctrl_wdata   = wdata_q;
    assign vtc_ctrl_wstrb   = 4'hF;
    assign vtc_ctrl_wvalid  = wvalid_q;
    assign vtc_ctrl_bready  = (state_q == S_WRESP);

`ifdef VTC_READBACK_EN
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
        end else begin
            arvalid_q <= arvalid_d;
            araddr_q  <= araddr_d;
        end
    end

    assign vtc_ctrl_arvalid = arvalid_q;
    assign vtc_ctrl_araddr  = araddr_q;
    assign vtc_ctrl_rready  = (state_q == S_RB_R);
`else
    logic unused_rd_chan;
    assign unused_rd_chan   = ^{vtc_ctrl_arready, vtc_ctrl_rdata, vtc_ctrl_rresp, vtc_ctrl_rvalid};
    assign vtc_ctrl_arvalid = 1'b0;
    assign vtc_ctrl_araddr  = '0;
    assign vtc_ctrl_rready  = 1'b0;
`endif

endmodule
